// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-to-sram-like data bridge.
//   bus_state_e : bridge FSM states (IDLE/ADDR/DATA/DONE)
//   SZ_*        : sram-like bus size codes (log2 of bytes transferred)
//   log2_bytes  : byte count (1/2/4/8) to size code
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } bus_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic [1:0] log2_bytes(input int n);
    case (n)
      1:       return SZ_B;
      2:       return SZ_H;
      4:       return SZ_W;
      8:       return SZ_D;
      default: return SZ_B;
    endcase
  endfunction

endpackage

// File: rtl/strb_to_size.sv
// Combinational mapping of a byte write mask to sram-like size and address.
//   wen_i  : byte write mask (0 = read)
//   addr_i : CPU byte address
//   size_o : bus size code
//   addr_o : bus address (low bits replaced by the lowest strobe index, or
//            cleared for a full-width access)
// A contiguous, naturally aligned mask of a power-of-two byte count maps to a
// narrow transfer; reads and every other mask fall back to a full-width
// aligned transfer with the strobes left to qualify the bytes.
module strb_to_size
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int BE_W   = 4
) (
  input  logic [BE_W-1:0]   wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [1:0]        size_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam int         AL      = $clog2(BE_W);
  localparam logic [1:0] SZ_FULL = log2_bytes(BE_W);

  int              cnt;
  int              low;
  logic            found;
  logic [BE_W-1:0] span;
  logic            aligned_ok;
  logic [AL-1:0]   lo;

  always_comb begin
    cnt        = 0;
    low        = 0;
    found      = 1'b0;
    span       = '0;
    aligned_ok = 1'b0;
    size_o     = SZ_FULL;
    lo         = '0;

    for (int i = 0; i < BE_W; i++) begin
      if (wen_i[i]) begin
        cnt = cnt + 1;
        if (!found) begin
          low   = i;
          found = 1'b1;
        end
      end
    end

    // The mask is accepted only if it equals the solid run of cnt bytes
    // starting at its lowest set bit; this rejects holes such as 4'b0101.
    for (int i = 0; i < BE_W; i++) begin
      span[i] = (i >= low) && (i < low + cnt);
    end

    if (cnt != 0) begin
      aligned_ok = ((cnt & (cnt - 1)) == 0) && ((low % cnt) == 0) && (span == wen_i);
    end

    if (aligned_ok) begin
      size_o = log2_bytes(cnt);
      lo     = low[AL-1:0];
    end

    addr_o = {addr_i[ADDR_W-1:AL], lo};
  end

endmodule

// File: rtl/cpu_sram_like_bridge.sv
// Bridge from the core's single-cycle SRAM-style data port to a handshaked
// sram-like bus (req / addr_ok / data_ok).
//   clk, rst                 : clock, synchronous active-high reset
//   cpu_en, cpu_wen          : access request and byte write mask (0 = read)
//   cpu_addr, cpu_wdata      : byte address, lane-aligned write data
//   cpu_hold                 : pipeline frozen elsewhere; keep the result
//   cpu_rdata, cpu_stall     : held read data, pipeline freeze
//   bus_req .. bus_wdata     : request channel, held stable until addr_ok
//   bus_addr_ok, bus_data_ok : request accepted, write done / read valid
//   bus_rdata                : read data
// The request is captured on entry to ADDR so the bus sees stable values even
// if the core's port wiggles while stalled. Read data stays in cpu_rdata
// until the next read completes.
module cpu_sram_like_bridge
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_en,
  input  logic [DATA_W/8-1:0] cpu_wen,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_hold,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_stall,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int BE_W = DATA_W / 8;

  bus_state_e        state_q, state_d;
  logic [BE_W-1:0]   wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              latch_req;
  logic              cap_rdata;
  logic              is_read;

  assign is_read = (wen_q == '0);

  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    cap_rdata = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_en) begin
          latch_req = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (bus_addr_ok) begin
          if (bus_data_ok) begin
            cap_rdata = is_read;
            state_d   = DONE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bus_data_ok) begin
          cap_rdata = is_read;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Stay here while held so the same access is not issued twice.
        if (!cpu_hold) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wen_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_req) begin
        wen_q   <= cpu_wen;
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end
      if (cap_rdata) begin
        rdata_q <= bus_rdata;
      end
      // data_ok is only legal once the address phase has been accepted.
      assert (!(bus_data_ok && ((state_q == IDLE) || (state_q == ADDR && !bus_addr_ok))))
        else $warning("bridge protocol violation: data_ok before addr_ok (state %0d)", state_q);
    end
  end

  strb_to_size #(
    .ADDR_W (ADDR_W),
    .BE_W   (BE_W)
  ) u_strb_to_size (
    .wen_i  (wen_q),
    .addr_i (addr_q),
    .size_o (bus_size),
    .addr_o (bus_addr)
  );

  assign bus_req   = (state_q == ADDR) && !rst;
  assign bus_wr    = |wen_q;
  assign bus_wstrb = wen_q;
  assign bus_wdata = wdata_q;
  assign cpu_rdata = rdata_q;
  assign cpu_stall = !rst && (((state_q == IDLE) && cpu_en) || (state_q == ADDR) || (state_q == DATA));

endmodule

// File: tb/tb_cpu_sram_like_bridge.sv
module tb_cpu_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_hold;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int stall_cnt;

  always #5 clk = ~clk;

  cpu_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .cpu_en      (cpu_en),
    .cpu_wen     (cpu_wen),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_hold    (cpu_hold),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait-state write or read with full request-channel checks.
  task automatic xact(input string tag, input logic [3:0] wen, input logic [31:0] addr,
                      input logic [1:0] esz, input logic [31:0] eaddr, input logic ewr);
    cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = 32'h0102_0304;
    #1 chk({tag, "_idle_stall"}, cpu_stall, 1);
    step();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1;
    #1;
    chk({tag, "_req"},   bus_req,   1);
    chk({tag, "_wr"},    bus_wr,    ewr);
    chk({tag, "_size"},  bus_size,  esz);
    chk({tag, "_addr"},  bus_addr,  eaddr);
    chk({tag, "_wstrb"}, bus_wstrb, wen);
    chk({tag, "_wdata"}, bus_wdata, 32'h0102_0304);
    step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; cpu_en = 1'b0;
    #1 chk({tag, "_done_stall"}, cpu_stall, 0);
    step();
  endtask

  initial begin
    rst = 1'b1; cpu_en = 1'b0; cpu_wen = '0; cpu_addr = '0; cpu_wdata = '0; cpu_hold = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    step();
    step();

    // Reset gating: even with a request present nothing escapes during reset.
    cpu_en = 1'b1;
    #1;
    chk("rst_req",   bus_req,   0);
    chk("rst_stall", cpu_stall, 0);
    cpu_en = 1'b0;
    rst = 1'b0;
    step();
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_idle_stall", cpu_stall, 0);

    // Read, no wait states.
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h1F00_0006;
    #1;
    chk("rd_idle_stall", cpu_stall, 1);
    chk("rd_idle_req",   bus_req,   0);
    step();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_req",   bus_req,   1);
    chk("rd_wr",    bus_wr,    0);
    chk("rd_addr",  bus_addr,  32'h1F00_0004);
    chk("rd_size",  bus_size,  2);
    chk("rd_wstrb", bus_wstrb, 4'b0000);
    chk("rd_stall", cpu_stall, 1);
    step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
    #1;
    chk("rd_done_stall", cpu_stall, 0);
    chk("rd_done_req",   bus_req,   0);
    chk("rd_rdata",      cpu_rdata, 32'hDEAD_BEEF);
    cpu_en = 1'b0;
    step();

    // Byte store with 3 address-phase and 2 data-phase cycles; the core's port
    // is scrambled after the request cycle to show the bus holds the capture.
    stall_cnt = 0;
    cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h0000_0100; cpu_wdata = 32'hAABB_CCDD;
    #1;
    if (cpu_stall) stall_cnt++;
    step();
    cpu_wen = 4'b1111; cpu_addr = 32'hFFFF_FFF0; cpu_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      bus_addr_ok = (k == 2);
      #1;
      if (cpu_stall) stall_cnt++;
      chk("sb_req",   bus_req,   1);
      chk("sb_wr",    bus_wr,    1);
      chk("sb_size",  bus_size,  0);
      chk("sb_addr",  bus_addr,  32'h0000_0102);
      chk("sb_wstrb", bus_wstrb, 4'b0100);
      chk("sb_wdata", bus_wdata, 32'hAABB_CCDD);
      step();
    end
    bus_addr_ok = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus_data_ok = (k == 1);
      bus_rdata   = (k == 1) ? 32'h1234_5678 : 32'h0;
      #1;
      if (cpu_stall) stall_cnt++;
      chk("sb_data_req", bus_req, 0);
      step();
    end
    bus_data_ok = 1'b0; bus_rdata = 32'h0; cpu_en = 1'b0;
    #1;
    if (cpu_stall) stall_cnt++;
    chk("sb_stall_cycles", stall_cnt, 6);
    chk("sb_rdata_kept",   cpu_rdata, 32'hDEAD_BEEF);
    step();

    // Size / address mapping for assorted masks.
    xact("sh",   4'b1100, 32'h0000_0200, 2'd1, 32'h0000_0202, 1'b1);
    xact("odd",  4'b0101, 32'h0000_0203, 2'd2, 32'h0000_0200, 1'b1);
    xact("mis",  4'b0110, 32'h0000_0301, 2'd2, 32'h0000_0300, 1'b1);
    xact("sw",   4'b1111, 32'h0000_0007, 2'd2, 32'h0000_0004, 1'b1);
    xact("sb3",  4'b1000, 32'h0000_0010, 2'd0, 32'h0000_0013, 1'b1);

    // Hold in DONE with the request still asserted.
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0300;
    step();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0; cpu_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("hold_req",   bus_req,   0);
      chk("hold_stall", cpu_stall, 0);
      chk("hold_rdata", cpu_rdata, 32'hCAFE_F00D);
      step();
    end
    cpu_hold = 1'b0;
    step();
    // Back in IDLE: the next request issues normally.
    cpu_addr = 32'h0000_0404;
    #1 chk("rel_idle_stall", cpu_stall, 1);
    step();
    bus_addr_ok = 1'b1;
    #1;
    chk("rel_req",  bus_req,  1);
    chk("rel_addr", bus_addr, 32'h0000_0404);
    step();
    bus_addr_ok = 1'b0;
    #1;
    chk("rel_data_req",   bus_req,   0);
    chk("rel_data_stall", cpu_stall, 1);

    // Reset while in DATA abandons the transfer.
    rst = 1'b1; cpu_en = 1'b0;
    #1;
    chk("mrst_req_now",   bus_req,   0);
    chk("mrst_stall_now", cpu_stall, 0);
    step();
    rst = 1'b0;
    #1;
    chk("mrst_req",   bus_req,   0);
    chk("mrst_stall", cpu_stall, 0);
    chk("mrst_rdata", cpu_rdata, 32'h0);
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0040;
    #1 chk("mrst_idle_stall", cpu_stall, 1);
    step();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h55AA_55AA;
    #1 chk("mrst_new_req", bus_req, 1);
    step();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0; cpu_en = 1'b0;
    #1 chk("mrst_new_rdata", cpu_rdata, 32'h55AA_55AA);
    step();

    // Spurious data_ok in IDLE is ignored.
    bus_data_ok = 1'b1; bus_rdata = 32'h0000_0099;
    #1;
    chk("spur_req",   bus_req,   0);
    chk("spur_stall", cpu_stall, 0);
    step();
    bus_data_ok = 1'b0; bus_rdata = 32'h0;
    #1;
    chk("spur_req_after",   bus_req,   0);
    chk("spur_stall_after", cpu_stall, 0);
    chk("spur_rdata",       cpu_rdata, 32'h55AA_55AA);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_sram_like_bridge.md
Name: cpu_sram_like_bridge

Overview:
Converts the CPU pipeline's single-cycle SRAM-style data port (en, byte write-enable, addr, wdata, same-cycle rdata) into a handshaked sram-like bus (req/addr_ok/data_ok). Raises a pipeline stall while a transaction is in flight and holds read data until the pipeline advances. Parametrised in address and data width. Sits between the mips core data port and the top-level bus, replacing the direct data SRAM wiring; one instance per data channel, and the same bridge can front the instruction port with wen tied to zero.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits; multiple of 8, power of two, 16 to 64
BE_W, DATA_W/8, localparam; byte-enable width
SZ_FULL, log2(BE_W), localparam; size code for a full-width access

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cpu_en  in  1  access request this cycle (memread|memwrite)
cpu_wen  in  BE_W  byte write mask; 0 = read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  DATA_W  write data, lane-aligned
cpu_hold  in  1  pipeline frozen for another reason; keep the result
cpu_rdata  out  DATA_W  read data, held stable in DONE
cpu_stall  out  1  freeze the pipeline
bus_req  out  1  request valid
bus_wr  out  1  1 = write
bus_size  out  2  log2 of bytes transferred
bus_addr  out  ADDR_W  transfer address
bus_wstrb  out  BE_W  write strobes
bus_wdata  out  DATA_W  write data
bus_addr_ok  in  1  request accepted
bus_data_ok  in  1  write complete or read data valid
bus_rdata  in  DATA_W  read data

Behaviour:
- States: IDLE, ADDR, DATA, DONE. Reset sets state IDLE and clears all request registers and cpu_rdata to 0. While rst is high, bus_req=0 and cpu_stall=0.
- IDLE: if cpu_en, latch wen/addr/wdata into request registers and go to ADDR. Otherwise stay in IDLE.
- ADDR: bus_req=1, and all bus_* outputs are driven from the registers and held stable until addr_ok.
  - addr_ok && data_ok in the same cycle: capture rdata and go to DONE.
  - addr_ok alone: go to DATA.
  - Otherwise stay in ADDR.
- DATA: bus_req=0. On data_ok, capture bus_rdata into cpu_rdata (reads only; writes leave it unchanged) and go to DONE.
- DONE: cpu_stall=0. If cpu_hold is low, go to IDLE; otherwise stay in DONE and do not re-issue, even though cpu_en is still high.
- cpu_stall = (IDLE && cpu_en) || ADDR || DATA. This is combinational from state and cpu_en.
- Minimum latency with addr_ok and data_ok both in the first ADDR cycle: stall is high for 2 cycles, and the result is valid in the DONE cycle.
- data_ok arriving in IDLE, or in ADDR before addr_ok, is a protocol violation. It is ignored and a simulation assertion fires.
- Size and address mapping:
  - Read (wen==0): bus_size=SZ_FULL, bus_addr = cpu_addr with the low log2(BE_W) bits cleared, bus_wstrb=0. The CPU performs lane extraction.
  - Write with a contiguous, naturally aligned mask of 1, 2, 4 … BE_W bytes: bus_size = log2(popcount), and the low bits of bus_addr = index of the lowest set strobe.
  - Any other nonzero mask: bus_size=SZ_FULL with an aligned address, and the strobes are passed through unchanged.
- bus_wdata is cpu_wdata unchanged, never shifted. bus_wr = |wen.
- Reset mid-operation returns the block to IDLE immediately and abandons the transaction. The bus slave shares rst; no drop tracking.

Decomposition:
- Shared package cpu_bus_pkg holds: the state enum (IDLE/ADDR/DATA/DONE, 2-bit), size codes SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3, and a function computing log2 of a byte count.
- One combinational sub-module, strb_to_size: maps the BE_W mask and address to bus_size and the aligned low address bits, including the fallback for non-contiguous masks. The FSM and registers live in the top module.

Test Plan:
- Read, no wait states: cpu_en=1, wen=0, addr=0x1F00_0006. addr_ok and data_ok in the first ADDR cycle with rdata=0xDEAD_BEEF -> bus_addr=0x1F00_0004, size=2, stall high for 2 cycles, cpu_rdata=0xDEAD_BEEF in DONE.
- Byte store with waits: wen=4'b0100, addr=0x100, addr_ok after 3 cycles, data_ok 2 cycles later -> bus_wr=1, size=0, bus_addr=0x102, wstrb=0100, bus outputs stable throughout ADDR, stall high for 6 cycles.
- Halfword and odd mask: wen=4'b1100 -> size=1, addr low bits=2. wen=4'b0101 -> size=2, aligned address, wstrb=0101.
- Hold in DONE: cpu_hold=1 for 4 cycles after data_ok with cpu_en still high -> stays in DONE, no new bus_req, cpu_rdata constant. Release -> IDLE, and the next request issues normally.
- Reset mid-transaction: rst=1 in the DATA state -> next cycle state=IDLE, bus_req=0, stall=0, cpu_rdata=0.
- Spurious data_ok in IDLE -> ignored, state unchanged, assertion reported.
